// File: rtl/fp32_mul.sv
// FP32 multiplier, y = a*b, three-stage pipeline feeding the PE adder.
// Normals and +/-0 only: subnormals flush to zero, truncate rounding, NaN treated as Inf.
module fp32_mul #(
    parameter int PIPE_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] y,
    output logic        ovf,
    output logic        unf
);

    generate
        if (PIPE_STAGES != 3) begin : g_bad_depth
            $error("fp32_mul: only PIPE_STAGES == 3 is supported");
        end
    endgenerate

    // Normalize (at most one bit), truncate, and saturate; returns {ovf, unf, y}.
    function automatic logic [33:0] pack_result(
        input logic              sign,
        input logic              zero,
        input logic              inf,
        input logic signed [9:0] es,
        input logic [47:0]       p
    );
        logic signed [9:0] e;
        logic [22:0]       frac;
        e    = p[47] ? (es + 10'sd1) : es;
        frac = p[47] ? p[46:24] : p[45:23];
        if (zero)
            pack_result = {2'b00, sign, 31'h0};
        else if (inf)
            pack_result = {2'b00, sign, 8'hFF, 23'h0};
        else if (e >= 10'sd255)
            pack_result = {2'b10, sign, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            pack_result = {2'b01, sign, 31'h0};
        else
            pack_result = {2'b00, sign, e[7:0], frac};
    endfunction

    logic              sign_p1_d, zero_p1_d, inf_p1_d;
    logic signed [9:0] es_p1_d;
    logic [23:0]       ma_p1_d, mb_p1_d;
    logic              sign_p1_q, zero_p1_q, inf_p1_q;
    logic signed [9:0] es_p1_q;
    logic [23:0]       ma_p1_q, mb_p1_q;
    logic              vld_p1_q;

    logic              sign_p2_q, zero_p2_q, inf_p2_q;
    logic signed [9:0] es_p2_q;
    logic [47:0]       prod_p2_d, prod_p2_q;
    logic              vld_p2_q;

    logic [33:0]       res_p3_d;
    logic [31:0]       y_q;
    logic              ovf_q, unf_q, vld_p3_q;

    // Stage 1: unpack operands
    always_comb begin
        sign_p1_d = a[31] ^ b[31];
        zero_p1_d = (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
        inf_p1_d  = ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) && !zero_p1_d;
        es_p1_d   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        ma_p1_d   = {1'b1, a[22:0]};
        mb_p1_d   = {1'b1, b[22:0]};
    end

    // Stage 2: mantissa product
    always_comb begin
        prod_p2_d = {24'h0, ma_p1_q} * {24'h0, mb_p1_q};
    end

    // Stage 3: normalize and pack
    always_comb begin
        res_p3_d = pack_result(sign_p2_q, zero_p2_q, inf_p2_q, es_p2_q, prod_p2_q);
    end

    always_ff @(posedge clk) begin
        sign_p1_q <= sign_p1_d;
        zero_p1_q <= zero_p1_d;
        inf_p1_q  <= inf_p1_d;
        es_p1_q   <= es_p1_d;
        ma_p1_q   <= ma_p1_d;
        mb_p1_q   <= mb_p1_d;
        sign_p2_q <= sign_p1_q;
        zero_p2_q <= zero_p1_q;
        inf_p2_q  <= inf_p1_q;
        es_p2_q   <= es_p1_q;
        prod_p2_q <= prod_p2_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            y_q      <= 32'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            vld_p1_q <= valid_in;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            y_q      <= res_p3_d[31:0];
            ovf_q    <= res_p3_d[33];
            unf_q    <= res_p3_d[32];
        end
    end

    assign valid_out = vld_p3_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp32_mul.sv
// Bench for fp32_mul: directed vector table, reset/latency sequence, random stream vs model.
module tb_fp32_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] a, b;
    logic        valid_out;
    logic [31:0] y;
    logic        ovf, unf;

    int n_vec  = 0;
    int n_miss = 0;

    fp32_mul #(.PIPE_STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b),
        .valid_out(valid_out), .y(y), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];

    // Reference: exact integer product of the significands, normalized by a loop.
    function automatic void ref_mul(input logic [31:0] ia, input logic [31:0] ib,
                                    output logic [31:0] ry, output logic ro, output logic ru);
        int              ea, eb, e;
        longint unsigned p;
        logic            s;
        s  = ia[31] ^ ib[31];
        ea = int'(ia[30:23]);
        eb = int'(ib[30:23]);
        ro = 1'b0;
        ru = 1'b0;
        if (ea == 0 || eb == 0) begin
            ry = {s, 31'h0};
        end else if (ea == 255 || eb == 255) begin
            ry = {s, 8'hFF, 23'h0};
        end else begin
            p = longint'({1'b1, ia[22:0]}) * longint'({1'b1, ib[22:0]});
            e = ea + eb - 127;
            while (p >= (64'd1 << 47)) begin
                p = p >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                ry = {s, 8'hFF, 23'h0};
                ro = 1'b1;
            end else if (e <= 0) begin
                ry = {s, 31'h0};
                ru = 1'b1;
            end else begin
                ry = {s, e[7:0], p[45:23]};
            end
        end
    endfunction

    task automatic seed_queue();
        exp_q.delete();
        exp_q.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
        exp_q.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    endtask

    task automatic step(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ey, input logic eo, input logic eu);
        exp_t e;
        valid_in = v;
        a        = ia;
        b        = ib;
        @(posedge clk);
        exp_q.push_back('{v, ey, eo, eu});
        #1;
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            n_vec++;
            if (valid_out !== e.v) begin
                n_miss++;
                $display("FAIL valid_out: got %0b expected %0b at %0t", valid_out, e.v, $time);
            end
            if (e.v) begin
                n_vec++;
                if (y !== e.y || ovf !== e.ovf || unf !== e.unf) begin
                    n_miss++;
                    $display("FAIL result: got y=%h ovf=%0b unf=%0b expected y=%h ovf=%0b unf=%0b",
                             y, ovf, unf, e.y, e.ovf, e.unf);
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        n_vec++;
        if (valid_out !== 1'b0 || y !== 32'h0 || ovf !== 1'b0 || unf !== 1'b0) begin
            n_miss++;
            $display("FAIL %s: got valid_out=%0b y=%h ovf=%0b unf=%0b expected all zero",
                     tag, valid_out, y, ovf, unf);
        end
    endtask

    vec_t tbl[15];

    initial begin
        logic [31:0] ra, rb, ry;
        logic        ro, ru, rv;
        int          done;

        tbl[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        tbl[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0};
        tbl[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
        tbl[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0};
        tbl[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0};
        tbl[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1};
        tbl[6]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0};
        tbl[7]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
        tbl[8]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0};
        tbl[9]  = '{32'h00000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0};
        tbl[10] = '{32'hFF000000, 32'h40000000, 32'hFF800000, 1'b1, 1'b0};
        tbl[11] = '{32'h80800000, 32'h3F000000, 32'h80000000, 1'b0, 1'b1};
        tbl[12] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0};
        tbl[13] = '{32'h7FC00000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0};
        tbl[14] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};

        rst_n    = 1'b0;
        valid_in = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        seed_queue();

        for (int i = 0; i < 15; i++)
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].ovf, tbl[i].unf);
        repeat (3) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Mid-stream reset: in-flight ops must vanish, outputs clear at once.
        for (int i = 0; i < 4; i++)
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].ovf, tbl[i].unf);
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        check_reset_state("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        seed_queue();
        step(1'b1, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        repeat (5) step(1'b0, 32'h3FC00000, 32'h40000000, 32'h0, 1'b0, 1'b0);

        done = 0;
        while (done < 200) begin
            rv = ($urandom_range(0, 3) != 0);
            ra[31]    = 1'($urandom_range(0, 1));
            rb[31]    = 1'($urandom_range(0, 1));
            ra[22:0]  = 23'($urandom);
            rb[22:0]  = 23'($urandom);
            ra[30:23] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 254))
                                                    : 8'($urandom_range(90, 164));
            rb[30:23] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 254))
                                                    : 8'($urandom_range(90, 164));
            ref_mul(ra, rb, ry, ro, ru);
            if (rv) begin
                step(1'b1, ra, rb, ry, ro, ru);
                done++;
            end else begin
                step(1'b0, ra, rb, 32'h0, 1'b0, 1'b0);
            end
        end
        repeat (3) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
